// File: rtl/spi_dma_rx_if.sv
// DMA write port between the SPI receiver (master side) and the RAM arbiter (slave side).
interface spi_dma_rx_if;
    logic        dma_en_o;
    logic [31:0] dma_addr_o;
    logic        dma_wr_o;
    logic [31:0] dma_wdata_o;
    logic        dma_busy_i;

    // Handshake: dma_wr_o is a one-cycle strobe raised only after a cycle with dma_busy_i low;
    // dma_addr_o/dma_wdata_o stay stable from one strobe until the next.
    modport master (output dma_en_o, dma_addr_o, dma_wr_o, dma_wdata_o, input dma_busy_i);
    modport slave  (input dma_en_o, dma_addr_o, dma_wr_o, dma_wdata_o, output dma_busy_i);
endinterface

// File: rtl/spi_dma_rx.sv
// SPI mode-0 slave receiver: packs MOSI bytes little-endian into 32-bit words and
// writes them to RAM through the DMA port; MISO repeats a programmable response byte.
module spi_dma_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_clk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [3:0]  reg_addr_we,
    input  logic [31:0] reg_addr_i,
    input  logic [3:0]  reg_count_we,
    input  logic [31:0] reg_count_i,
    input  logic [3:0]  reg_dat_we,
    input  logic [31:0] reg_dat_di,
    output logic [31:0] reg_dat_do,
    output logic [31:0] reg_conf_do,
    spi_dma_rx_if.master dma
);
    typedef enum logic [0:0] {IDLE = 1'b0, ARMED = 1'b1} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic        sclk_d, cs_d;
    logic [31:0] addr, addr_out, wdata_out, hold, word;
    logic [15:0] count;
    logic [7:0]  tx_byte, rx_byte, shift;
    logic [2:0]  bitcnt, miso_idx;
    logic [1:0]  bytecnt;
    logic        pend, overflow, dma_wr, miso;

    logic sclk_s, cs_low, mosi_s, sclk_rise, sclk_fall, cs_fall;
    logic strobe, byte_done, word_done, count_wr;
    logic [15:0] count_in;
    logic [7:0]  new_byte;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_low    = ~cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = cs_low & cs_d;

    assign strobe    = pend & ~dma.dma_busy_i & ~dma_wr;
    assign count_wr  = |reg_count_we;
    assign count_in  = reg_count_i[17:2];
    assign new_byte  = {shift[6:0], mosi_s};
    assign byte_done = (state_q == ARMED) & cs_low & sclk_rise & (bitcnt == 3'd7);
    assign word_done = byte_done & (bytecnt == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            state_q   <= IDLE;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_s;
            cs_d      <= ~cs_low;
            state_q   <= state_d;
        end
    end

    // Arming only from IDLE with a nonzero word count; the last strobe returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_wr && count_in != 16'd0) state_d = ARMED;
            ARMED:   if (strobe && count == 16'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr      <= '0;
            addr_out  <= '0;
            wdata_out <= '0;
            hold      <= '0;
            word      <= '0;
            count     <= '0;
            tx_byte   <= '0;
            rx_byte   <= '0;
            shift     <= '0;
            bitcnt    <= '0;
            bytecnt   <= '0;
            miso_idx  <= '0;
            pend      <= 1'b0;
            overflow  <= 1'b0;
            dma_wr    <= 1'b0;
            miso      <= 1'b0;
        end else begin
            dma_wr <= strobe;
            if (strobe) begin
                addr_out  <= addr;
                wdata_out <= hold;
                addr      <= addr + 32'd1;
                if (count != 16'd0) count <= count - 16'd1;
                pend      <= 1'b0;
            end

            if (state_q == IDLE) begin
                bitcnt  <= '0;
                bytecnt <= '0;
                if (|reg_addr_we) addr <= {10'b0, reg_addr_i[23:2]};
                if (count_wr) begin
                    count <= count_in;
                    if (count_in != 16'd0) overflow <= 1'b0;
                end
            end else if (!cs_low) begin
                bitcnt  <= '0;
                bytecnt <= '0;
            end else if (sclk_rise) begin
                shift  <= new_byte;
                bitcnt <= bitcnt + 3'd1;
                if (byte_done) begin
                    rx_byte                    <= new_byte;
                    word[{bytecnt, 3'b000} +: 8] <= new_byte;
                    bytecnt                    <= bytecnt + 2'd1;
                end
                // A word finishing while the previous one still waits is dropped.
                if (word_done) begin
                    if (pend) begin
                        overflow <= 1'b1;
                    end else begin
                        hold <= {new_byte, word[23:0]};
                        pend <= 1'b1;
                    end
                end
            end

            if (reg_dat_we[0]) tx_byte <= reg_dat_di[7:0];

            if (cs_fall) begin
                miso     <= tx_byte[7];
                miso_idx <= 3'd6;
            end else if (cs_low && sclk_fall) begin
                miso     <= tx_byte[miso_idx];
                miso_idx <= miso_idx - 3'd1;
            end
        end
    end

    assign spi_miso        = miso;
    assign reg_dat_do      = {24'b0, rx_byte};
    assign reg_conf_do     = {29'b0, overflow, state_q == ARMED, (state_q == IDLE) & ~pend};
    assign dma.dma_en_o    = |count;
    assign dma.dma_addr_o  = addr_out;
    assign dma.dma_wr_o    = dma_wr;
    assign dma.dma_wdata_o = wdata_out;

    logic unused_bits;
    assign unused_bits = ^{reg_addr_i[31:24], reg_addr_i[1:0], reg_count_i[31:18],
                           reg_count_i[1:0], reg_dat_we[3:1], reg_dat_di[31:8]};
endmodule

// File: tb/tb_spi_dma_rx.sv
// Randomised bench for spi_dma_rx: a byte-stream model predicts every DMA word/address,
// MISO bit and status register value.
module tb_spi_dma_rx;
    logic        clk = 1'b0;
    logic        reset;
    logic        spi_clk, spi_cs_n, spi_mosi, spi_miso;
    logic [3:0]  reg_addr_we, reg_count_we, reg_dat_we;
    logic [31:0] reg_addr_i, reg_count_i, reg_dat_di, reg_dat_do, reg_conf_do;

    spi_dma_rx_if dma_if ();

    spi_dma_rx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .reg_addr_we(reg_addr_we), .reg_addr_i(reg_addr_i),
        .reg_count_we(reg_count_we), .reg_count_i(reg_count_i),
        .reg_dat_we(reg_dat_we), .reg_dat_di(reg_dat_di),
        .reg_dat_do(reg_dat_do), .reg_conf_do(reg_conf_do),
        .dma(dma_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  partial[$];
    int          model_count;
    logic [31:0] model_addr;
    logic [7:0]  model_tx, model_last;
    logic        model_ovf;
    bit          check_miso;
    int          strobes;
    time         last_strobe_t;
    logic        prev_wr;
    bit          round_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_addr_q.delete();
        exp_q.delete();
        partial.delete();
        model_count = 0;
        model_addr  = '0;
        model_tx    = '0;
        model_last  = '0;
        model_ovf   = 1'b0;
    endtask

    // A received byte only counts while words remain; four bytes make a little-endian word.
    task automatic model_accept(input logic [7:0] b);
        logic [31:0] w;
        if (model_count != 0) begin
            model_last = b;
            partial.push_back(b);
            if (partial.size() == 4) begin
                w = {partial[3], partial[2], partial[1], partial[0]};
                partial.delete();
                if (exp_q.size() != 0) begin
                    model_ovf = 1'b1;
                end else begin
                    exp_addr_q.push_back(model_addr);
                    exp_q.push_back(w);
                    model_addr = model_addr + 32'd1;
                end
            end
        end
    endtask

    // Compare process: every DMA strobe is matched against the model's next word.
    always @(negedge clk) begin
        if (!reset) begin
            if (dma_if.dma_wr_o) begin
                strobes++;
                last_strobe_t = $time;
                if (prev_wr) check("wr_single_cycle", 32'd1, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe_addr", dma_if.dma_addr_o, 32'hFFFF_FFFF);
                end else begin
                    check("dma_addr", dma_if.dma_addr_o, exp_addr_q.pop_front());
                    check("dma_wdata", dma_if.dma_wdata_o, exp_q.pop_front());
                    if (model_count > 0) model_count--;
                end
            end
            prev_wr = dma_if.dma_wr_o;
        end else begin
            prev_wr = 1'b0;
        end
    end

    task automatic reg_write(input int which, input logic [31:0] d);
        @(negedge clk);
        case (which)
            0: begin
                reg_addr_we = 4'hF; reg_addr_i = d;
                if (model_count == 0) model_addr = {10'b0, d[23:2]};
            end
            1: begin
                reg_count_we = 4'hF; reg_count_i = d;
                if (model_count == 0) begin
                    model_count = int'(d[17:2]);
                    if (d[17:2] != 16'd0) model_ovf = 1'b0;
                end
            end
            default: begin
                reg_dat_we = 4'h1; reg_dat_di = d;
                model_tx = d[7:0];
            end
        endcase
        @(negedge clk);
        reg_addr_we = '0; reg_count_we = '0; reg_dat_we = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cs_assert();
        spi_cs_n = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic cs_release();
        spi_cs_n = 1'b1;
        partial.delete();
        repeat (10) @(negedge clk);
    endtask

    // Mode 0, sclk = clk/10: MOSI changes while sclk is low, master samples MISO on the rise.
    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = b[i];
            repeat (5) @(negedge clk);
            spi_clk = 1'b1;
            if (check_miso) check("miso_bit", {31'b0, spi_miso}, {31'b0, model_tx[i]});
            if (i == 0) model_accept(b);
            repeat (5) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL dma_timeout: got %0d words outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic check_state(input string name);
        wait_done(400);
        repeat (4) @(negedge clk);
        check({name, "_conf"}, reg_conf_do,
              {29'b0, model_ovf, model_count != 0, model_count == 0 && exp_q.size() == 0});
        check({name, "_en"}, {31'b0, dma_if.dma_en_o}, {31'b0, model_count != 0});
        check({name, "_dat_do"}, reg_dat_do, {24'b0, model_last});
    endtask

    initial begin
        int s0;
        time t0;
        logic [7:0] b;
        int words;

        reset = 1'b1;
        spi_clk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        reg_addr_we = '0; reg_count_we = '0; reg_dat_we = '0;
        reg_addr_i = '0; reg_count_i = '0; reg_dat_di = '0;
        dma_if.dma_busy_i = 1'b0;
        strobes = 0; prev_wr = 1'b0; check_miso = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_conf", reg_conf_do, 32'h1);
        check("rst_en", {31'b0, dma_if.dma_en_o}, 32'd0);
        check("rst_wr", {31'b0, dma_if.dma_wr_o}, 32'd0);
        check("rst_addr_o", dma_if.dma_addr_o, 32'd0);
        check("rst_miso", {31'b0, spi_miso}, 32'd0);

        // Basic: two words from address 0x100
        reg_write(0, 32'h100);
        reg_write(1, 32'd8);
        check("armed_conf", reg_conf_do, 32'h2);
        cs_assert();
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        cs_release();
        check_state("basic");
        check("basic_last_addr", dma_if.dma_addr_o, 32'h41);
        check("basic_last_data", dma_if.dma_wdata_o, 32'h0807_0605);
        check("basic_idle_conf", reg_conf_do, 32'h1);
        // Bits after completion are ignored
        s0 = strobes;
        cs_assert();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)));
        cs_release();
        check("ignored_strobes", 32'(strobes - s0), 32'd0);
        check_state("ignored");

        // Busy stall during the first word
        reg_write(0, 32'h0000_2000);
        reg_write(1, 32'd8);
        dma_if.dma_busy_i = 1'b1;
        cs_assert();
        fork
            for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)));
            begin
                for (int i = 0; i < 2000 && exp_q.size() == 0; i++) @(negedge clk);
                repeat (50) @(negedge clk);
                check("stall_held", 32'(exp_q.size()), 32'd1);
                dma_if.dma_busy_i = 1'b0;
                t0 = $time;
                repeat (2) @(negedge clk);
                check("stall_release_latency", 32'(last_strobe_t - t0), 32'd10);
            end
        join
        cs_release();
        check_state("stall");

        // Overflow: second word arrives while the first is still pending
        reg_write(0, 32'h0000_0400);
        reg_write(1, 32'd8);
        dma_if.dma_busy_i = 1'b1;
        s0 = strobes;
        cs_assert();
        for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)));
        cs_release();
        repeat (20) @(negedge clk);
        check("ovf_no_strobe_yet", 32'(strobes - s0), 32'd0);
        check("ovf_conf_pending", reg_conf_do, 32'h6);
        dma_if.dma_busy_i = 1'b0;
        repeat (10) @(negedge clk);
        check("ovf_one_strobe", 32'(strobes - s0), 32'd1);
        check("ovf_conf_literal", reg_conf_do, 32'h6);
        check_state("ovf_after");
        cs_assert();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)));
        cs_release();
        check_state("ovf_done");
        check("ovf_done_conf", reg_conf_do, 32'h5);

        // CS abort discards the partial word
        reg_write(1, 32'd4);
        cs_assert();
        send_byte(8'h11);
        send_byte(8'h22);
        cs_release();
        cs_assert();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        cs_release();
        check_state("abort");
        check("abort_word", dma_if.dma_wdata_o, 32'hDDCC_BBAA);

        // MISO response byte; count rewrite while armed is ignored
        reg_write(2, 32'hA5);
        reg_write(1, 32'd4);
        reg_write(1, 32'h100);
        cs_assert();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)));
        cs_release();
        check_state("miso");

        // Randomised transfers with random busy pulses and aborted partial bytes
        for (int r = 0; r < 6; r++) begin
            reg_write(2, 32'($urandom_range(0, 255)));
            reg_write(0, $urandom());
            words = $urandom_range(1, 3);
            reg_write(1, 32'(words * 4));
            if ($urandom_range(0, 1) == 1) begin
                cs_assert();
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) send_byte(8'($urandom_range(0, 255)));
                cs_release();
            end
            round_done = 1'b0;
            cs_assert();
            fork
                begin
                    for (int i = 0; i < words * 4; i++) send_byte(8'($urandom_range(0, 255)));
                    round_done = 1'b1;
                end
                while (!round_done) begin
                    repeat ($urandom_range(5, 60)) @(negedge clk);
                    dma_if.dma_busy_i = 1'b1;
                    repeat ($urandom_range(1, 20)) @(negedge clk);
                    dma_if.dma_busy_i = 1'b0;
                end
            join
            cs_release();
            check_state("random");
        end

        // Reset mid-shift with a pending word
        reg_write(0, 32'h0000_0800);
        reg_write(1, 32'd8);
        dma_if.dma_busy_i = 1'b1;
        cs_assert();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)));
        check_miso = 1'b0;
        b = 8'($urandom_range(0, 255));
        send_bits(b, 3);
        s0 = strobes;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("mid_rst_conf", reg_conf_do, 32'h1);
        check("mid_rst_wr", {31'b0, dma_if.dma_wr_o}, 32'd0);
        check("mid_rst_miso", {31'b0, spi_miso}, 32'd0);
        check("mid_rst_en", {31'b0, dma_if.dma_en_o}, 32'd0);
        check("mid_rst_dat", reg_dat_do, 32'd0);
        dma_if.dma_busy_i = 1'b0;
        cs_release();
        repeat (20) @(negedge clk);
        check("mid_rst_no_strobe", 32'(strobes - s0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/spi_dma_rx.md
Name: spi_dma_rx

Overview:
- SPI mode-0 slave receiver. Deserialises MOSI bytes, packs them into 32-bit words and writes them to RAM over the DMA write port.
- Complements the SPI DMA transmitter: byte order and address/count register semantics mirror it, so a stream sent by the transmitter lands in RAM unchanged.
- Sits on the picosoc register bus next to the SPI master, sharing the RAM arbiter's DMA port style.

Parameters:
SYNC_STAGES, 2, synchroniser flops on spi_clk/spi_cs_n/spi_mosi (min 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
spi_clk  input  1  SPI clock from external master, async
spi_cs_n  input  1  chip select, active-low, async
spi_mosi  input  1  serial data in, async
spi_miso  output  1  serial data out
reg_addr_we  input  4  byte-lane write enables, DMA start address
reg_addr_i  input  32  byte address; bits [23:2] used
reg_count_we  input  4  byte-lane write enables, transfer length (arms block)
reg_count_i  input  32  byte count; bits [17:2] used
reg_dat_we  input  4  write enables, MISO response byte
reg_dat_di  input  32  [7:0] = response byte
reg_dat_do  output  32  {24'b0, last complete received byte}
reg_conf_do  output  32  {29'b0, overflow, armed, idle}
dma_en_o  output  1  high while words remain (count != 0)
dma_addr_o  output  32  word address of write
dma_wr_o  output  1  one-cycle write strobe
dma_wdata_o  output  32  write data
dma_busy_i  input  1  RAM port busy; strobe only issued when low

Behaviour:
- Reset values: all outputs 0; spi_miso 0; word count 0; address 0; overflow 0; tx byte 0x00; state IDLE (reg_conf_do = 0x1).
- Synchronisation:
  - SPI inputs pass through SYNC_STAGES flops, plus one edge-detect flop.
  - An spi_clk edge is acted on SYNC_STAGES+1 clk later.
  - Requirement: f_clk >= 8 * f_sclk.
- States:
  - IDLE:
    - Register writes accepted here only; writes in other states are ignored.
    - Any reg_addr_we: addr <= {10'b0, reg_addr_i[23:2]}.
    - Any reg_count_we: count <= reg_count_i[17:2]. Nonzero -> ARMED and overflow cleared; zero -> stay IDLE.
    - reg_dat_we[0]: tx byte <= reg_dat_di[7:0] (accepted in any state).
  - ARMED:
    - Bit counter resets to 0 and the partial word is discarded while spi_cs_n is high.
    - spi_cs_n low, rising sclk: shift MOSI into byte (MSB first), bitcnt++.
    - 8th bit: byte written to reg_dat_do and into word lane bytecnt*8 (first byte -> [7:0], fourth -> [31:24]), bytecnt++.
    - 4th byte complete: word copied to holding register, pend=1.
  - Falling sclk with cs_n low: spi_miso <= next bit of tx byte, MSB first. Cs_n falling loads bit 7; tx byte repeats every byte.
- DMA write (concurrent with shifting):
  - When pend & !dma_busy_i & !dma_wr_o: dma_wr_o=1 for one cycle, dma_addr_o=addr, dma_wdata_o=holding word.
  - Same cycle: addr++, count--, pend=0.
  - dma_addr_o/dma_wdata_o hold until the next strobe.
- Completion: count reaches 0 -> IDLE. Further SPI bits are ignored. dma_en_o = |count.
- Overflow: word completes while pend=1 -> new word dropped, overflow=1 (sticky until next arm), count unchanged.
- Partial word at cs_n rise is discarded; the next transaction restarts at byte lane 0.
- idle = (state==IDLE) & !pend. armed = state==ARMED.
- Reset mid-transfer: everything returns to reset values within one cycle; any pending word is lost; no dma_wr_o after reset.
- Address arithmetic 32-bit, wraps at 2^32 (upper bits zero by construction). Count 16-bit, never decrements below 0.

Test Plan:
- Reset: assert reset 2 clk mid-shift -> reg_conf_do=0x1, dma_wr_o=0, spi_miso=0, dma_en_o=0.
- Basic: addr=0x100, count=8, sclk=clk/10, send 01 02 03 04 05 06 07 08 -> two strobes: (0x40, 0x04030201), (0x41, 0x08070605); then IDLE, dma_en_o=0.
- Busy stall: dma_busy_i high 50 clk during first word -> strobe issued first cycle busy low; no data loss with sclk=clk/10.
- Overflow: busy held high while 8 bytes arrive -> exactly one strobe after release, overflow bit=1, count=1, still ARMED.
- CS abort: 2 bytes, cs_n high, then AA BB CC DD -> single word 0xDDCCBBAA.
- MISO: tx byte 0xA5, count=4, 4 bytes clocked -> master samples A5 A5 A5 A5. Register write of count during ARMED is ignored.
